// File: rtl/pc_ir_if.sv
// Fetch-stage bus between the control unit / memories and pc_ir_unit.
interface pc_ir_if;
    // Control and data inputs to the fetch stage
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic [31:0] ins_in;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;

    // Fetch-stage state and decoded fields
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [31:0] fetch_cnt;
    logic        halted;
    logic        align_err;

    // Control unit / memory side
    modport master (
        output PCWre, PCSrc, IRWre, ins_in, imm_ext, rs_data,
        input  pc, pc_plus4, link_addr, ir, opcode, rs, rt, rd, sa, imm16,
               fetch_cnt, halted, align_err
    );

    // Fetch unit side
    modport slave (
        input  PCWre, PCSrc, IRWre, ins_in, imm_ext, rs_data,
        output pc, pc_plus4, link_addr, ir, opcode, rs, rt, rd, sa, imm16,
               fetch_cnt, halted, align_err
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Fetch-side datapath: program counter, next-PC mux, instruction register,
// field decode, jal link address, fetch counter, halt and alignment flags.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic   clk,
    input  logic   rst,
    pc_ir_if.slave bus
);

    localparam int unsigned W = 32;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JR     = 2'b10;
    localparam logic [1:0] SRC_JUMP   = 2'b11;

    logic [W-1:0] pc_q;
    logic [W-1:0] ir_q;
    logic [W-1:0] link_q;
    logic [W-1:0] cnt_q;
    logic         halted_q;
    logic         align_q;

    logic [W-1:0] pc_plus4;
    logic [W-1:0] npc;
    logic         pc_we;
    logic         ir_we;
    logic         halt_seen;

    assign pc_plus4  = pc_q + W'(4);
    assign pc_we     = bus.PCWre && !halted_q;
    assign ir_we     = bus.IRWre && !halted_q;
    assign halt_seen = (ir_q[31:26] == HALT_OP);

    // Next-PC select; all arithmetic wraps modulo 2^32
    always_comb begin
        npc = pc_plus4;
        case (bus.PCSrc)
            SRC_SEQ:    npc = pc_plus4;
            SRC_BRANCH: npc = pc_plus4 + W'(bus.imm_ext << 2);
            SRC_JR:     npc = bus.rs_data;
            SRC_JUMP:   npc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            default:    npc = pc_plus4;
        endcase
    end

    // PC register and sticky misalignment flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            align_q <= 1'b0;
        end else if (pc_we) begin
            pc_q <= {npc[31:2], 2'b00};
            if (npc[1:0] != 2'b00) begin
                align_q <= 1'b1;
            end
        end
    end

    // Instruction register, jal link address (old pc + 4) and fetch counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q   <= '0;
            link_q <= RESET_PC + W'(4);
            cnt_q  <= '0;
        end else if (ir_we) begin
            ir_q   <= bus.ins_in;
            link_q <= pc_plus4;
            cnt_q  <= cnt_q + W'(1);
        end
    end

    // Halt latch: set the edge after the halt opcode sits in IR, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else if (halt_seen) begin
            halted_q <= 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.link_addr = link_q;
    assign bus.ir        = ir_q;
    assign bus.opcode    = ir_q[31:26];
    assign bus.rs        = ir_q[25:21];
    assign bus.rt        = ir_q[20:16];
    assign bus.rd        = ir_q[15:11];
    assign bus.sa        = ir_q[10:6];
    assign bus.imm16     = ir_q[15:0];
    assign bus.fetch_cnt = cnt_q;
    assign bus.halted    = halted_q;
    assign bus.align_err = align_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit.
module tb_pc_ir_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_ir_if bus ();

    pc_ir_unit #(
        .RESET_PC(32'h0000_0000),
        .HALT_OP (6'b111111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PCWre   = 1'b0;
        bus.IRWre   = 1'b0;
        bus.PCSrc   = 2'b00;
        bus.ins_in  = 32'h0;
        bus.imm_ext = 32'h0;
        bus.rs_data = 32'h0;
    endtask

    // Place pc via a jr (PCSrc=10)
    task automatic set_pc(input logic [31:0] addr);
        bus.PCWre   = 1'b1;
        bus.IRWre   = 1'b0;
        bus.PCSrc   = 2'b10;
        bus.rs_data = addr;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp %h", bus.ir, 32'h0); end
        checks++; if (bus.link_addr !== 32'h4) begin errors++; $display("FAIL reset_link got %h exp %h", bus.link_addr, 32'h4); end
        checks++; if (bus.fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp %h", bus.fetch_cnt, 32'h0); end
        checks++; if (bus.opcode !== 6'b000000) begin errors++; $display("FAIL reset_opcode got %b exp %b", bus.opcode, 6'b000000); end
        checks++; if (bus.halted !== 1'b0 || bus.align_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", bus.halted, bus.align_err); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            bus.PCWre  = 1'b1;
            bus.IRWre  = 1'b1;
            bus.PCSrc  = 2'b00;
            bus.ins_in = 32'h0022_0820 + 32'(i);
            step();
            idle();
            checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, bus.pc, exp_pc[i]); end
            checks++; if (bus.link_addr !== exp_pc[i]) begin errors++; $display("FAIL seq_link%0d got %h exp %h", i, bus.link_addr, exp_pc[i]); end
        end
        checks++; if (bus.fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt got %0d exp %0d", bus.fetch_cnt, 3); end
        checks++; if (bus.ir !== 32'h0022_0822) begin errors++; $display("FAIL seq_ir got %h exp %h", bus.ir, 32'h0022_0822); end
        // PCWre low: pc holds
        step();
        checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL seq_hold got %h exp %h", bus.pc, 32'hC); end
    endtask

    task automatic test_branch();
        set_pc(32'h10);
        bus.PCWre   = 1'b1;
        bus.PCSrc   = 2'b01;
        bus.imm_ext = 32'hFFFF_FFFE;
        step();
        idle();
        checks++; if (bus.pc !== 32'h0C) begin errors++; $display("FAIL branch_back got %h exp %h", bus.pc, 32'h0C); end
        bus.PCWre   = 1'b1;
        bus.PCSrc   = 2'b01;
        bus.imm_ext = 32'h3;
        step();
        idle();
        checks++; if (bus.pc !== 32'h1C) begin errors++; $display("FAIL branch_fwd got %h exp %h", bus.pc, 32'h1C); end
    endtask

    task automatic test_jump();
        bus.IRWre  = 1'b1;
        bus.ins_in = 32'hE000_0040;
        step();
        idle();
        set_pc(32'h8000_0010);
        bus.PCWre = 1'b1;
        bus.PCSrc = 2'b11;
        step();
        idle();
        checks++; if (bus.pc !== 32'h8000_0100) begin errors++; $display("FAIL jump_pc got %h exp %h", bus.pc, 32'h8000_0100); end
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL jump_align got %b exp %b", bus.align_err, 1'b0); end
        bus.PCWre   = 1'b1;
        bus.PCSrc   = 2'b10;
        bus.rs_data = 32'h0000_0202;
        step();
        idle();
        checks++; if (bus.pc !== 32'h0000_0200) begin errors++; $display("FAIL jr_pc got %h exp %h", bus.pc, 32'h0000_0200); end
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL jr_align got %b exp %b", bus.align_err, 1'b1); end
        // Sticky across later aligned updates
        set_pc(32'h40);
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL align_sticky got %b exp %b", bus.align_err, 1'b1); end
    endtask

    task automatic test_back_to_back();
        set_pc(32'h20);
        bus.PCWre  = 1'b1;
        bus.IRWre  = 1'b1;
        bus.PCSrc  = 2'b00;
        bus.ins_in = 32'h0800_1234;
        step();
        idle();
        checks++; if (bus.ir !== 32'h0800_1234) begin errors++; $display("FAIL b2b_ir got %h exp %h", bus.ir, 32'h0800_1234); end
        checks++; if (bus.opcode !== 6'b000010) begin errors++; $display("FAIL b2b_opcode got %b exp %b", bus.opcode, 6'b000010); end
        checks++; if (bus.imm16 !== 16'h1234) begin errors++; $display("FAIL b2b_imm16 got %h exp %h", bus.imm16, 16'h1234); end
        checks++; if (bus.rd !== 5'd2 || bus.sa !== 5'd8 || bus.rs !== 5'd0 || bus.rt !== 5'd0) begin errors++; $display("FAIL b2b_fields got rs%0d rt%0d rd%0d sa%0d exp rs0 rt0 rd2 sa8", bus.rs, bus.rt, bus.rd, bus.sa); end
        checks++; if (bus.link_addr !== 32'h24) begin errors++; $display("FAIL b2b_link got %h exp %h", bus.link_addr, 32'h24); end
        checks++; if (bus.pc !== 32'h24) begin errors++; $display("FAIL b2b_pc got %h exp %h", bus.pc, 32'h24); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.PCWre  = 1'b1;
        bus.IRWre  = 1'b1;
        bus.PCSrc  = 2'b00;
        bus.ins_in = 32'hFC00_0000;
        step();
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp %b", bus.halted, 1'b0); end
        bus.ins_in = 32'h1234_5678;
        step();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp %b", bus.halted, 1'b1); end
        checks++; if (bus.pc !== 32'h8 || bus.ir !== 32'h1234_5678) begin errors++; $display("FAIL halt_last got pc %h ir %h exp pc %h ir %h", bus.pc, bus.ir, 32'h8, 32'h1234_5678); end
        bus.ins_in = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL halt_pc got %h exp %h", bus.pc, 32'h8); end
        checks++; if (bus.ir !== 32'h1234_5678) begin errors++; $display("FAIL halt_ir got %h exp %h", bus.ir, 32'h1234_5678); end
        checks++; if (bus.fetch_cnt !== 32'd2 || bus.link_addr !== 32'h8) begin errors++; $display("FAIL halt_cnt got %0d link %h exp 2 link %h", bus.fetch_cnt, bus.link_addr, 32'h8); end
        // Asynchronous reset mid-cycle
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL arst_halted got %b exp %b", bus.halted, 1'b0); end
        checks++; if (bus.pc !== 32'h0 || bus.ir !== 32'h0 || bus.fetch_cnt !== 32'h0 || bus.link_addr !== 32'h4) begin errors++; $display("FAIL arst_state got pc %h ir %h cnt %h link %h exp 0 0 0 4", bus.pc, bus.ir, bus.fetch_cnt, bus.link_addr); end
        idle();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp %h", bus.pc_plus4, 32'h0); end
        bus.PCWre = 1'b1;
        bus.PCSrc = 2'b00;
        step();
        idle();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", bus.pc, 32'h0); end
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL wrap_align got %b exp %b", bus.align_err, 1'b0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_back_to_back();
        test_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Fetch-side datapath stage of the multi-cycle CPU. It sits directly upstream of the control unit.
- Holds the program counter, computes the next PC from the control unit's PCSrc, latches the fetched instruction into the instruction register, and decodes instruction fields.
- Supplies opcode (and rs/rt/rd/sa/imm) to the control unit and register file; consumes PCWre, PCSrc and IRWre from the control unit.
- Also keeps the jal link address, a retired-fetch counter, a sticky halt latch and a sticky misalignment flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that sets the halt latch.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCWre  in  1  PC write enable from control unit.
- PCSrc  in  2  next-PC select: 00 seq, 01 branch, 10 jr, 11 j/jal.
- IRWre  in  1  instruction register write enable.
- ins_in  in  32  instruction memory read data, combinational from address pc.
- imm_ext  in  32  extended 16-bit immediate from the extender.
- rs_data  in  32  register-file rs read data (jr target).
- pc  out  32  current PC; drives instruction memory address.
- pc_plus4  out  32  pc + 4, combinational.
- link_addr  out  32  registered pc+4 of the instruction currently in IR (jal write data).
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- sa  out  5  ir[10:6].
- imm16  out  16  ir[15:0].
- fetch_cnt  out  32  number of IR loads since reset.
- halted  out  1  sticky halt flag.
- align_err  out  1  sticky; set on any misaligned next-PC.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - pc=RESET_PC, ir=0, link_addr=RESET_PC+4, fetch_cnt=0, halted=0, align_err=0.
  - opcode therefore reads 000000.
  - Reset mid-instruction discards all state with no partial update.
- Next-PC (combinational, npc):
  - 00: pc+4.
  - 01: pc+4 + (imm_ext<<2).
  - 10: rs_data.
  - 11: {pc_plus4[31:28], ir[25:0], 2'b00}.
  - All arithmetic is 32-bit modulo 2^32; wrap from FFFF_FFFC to 0000_0000 is legal and silent.
- PC register:
  - On rising clk with PCWre=1 and halted=0: pc<=npc with npc[1:0] forced to 00.
  - If npc[1:0]!=00 at that edge, align_err<=1 (sticky until reset).
  - PCWre=0 or halted=1: pc holds.
- IR:
  - On rising clk with IRWre=1 and halted=0: ir<=ins_in, link_addr<=pc+4 (pre-update pc), fetch_cnt<=fetch_cnt+1 (wraps at 2^32).
- Simultaneous PCWre and IRWre in one cycle:
  - IR, link_addr and fetch_cnt capture values based on the old pc.
  - pc takes npc, which is computed from the old ir.
- Halt:
  - After any edge where ir[31:26]==HALT_OP, halted<=1 on the next rising edge.
  - Once halted, pc, ir, link_addr and fetch_cnt freeze regardless of PCWre/IRWre. Only reset clears it.
- Field outputs are pure wiring from ir; no extra latency.
- Latency summary:
  - PC visible one edge after the PCWre edge.
  - Decoded opcode visible immediately after the IRWre edge; the control unit samples it in its next state.

Test Plan:
- Reset then 3 sequential fetches (PCSrc=00, IRWre=1/PCWre=1 pulsed per instruction) -> pc 0→4→8→C; fetch_cnt=3; link_addr=0000_000C after the third load.
- Branch: pc=0x10, imm_ext=FFFF_FFFE, PCSrc=01, PCWre=1 -> pc=0x0C. Then imm_ext=0x3, PCSrc=01 from pc=0x0C -> pc=0x1C.
- Jump: ir=0xE000_0040 (j, target 0x40), pc=0x8000_0010, PCSrc=11 -> pc=0x8000_0100. With jr, PCSrc=10, rs_data=0x0000_0202 -> pc=0x0000_0200 and align_err=1.
- Simultaneous PCWre/IRWre at pc=0x20, ins_in=0x0800_1234 -> ir=0x0800_1234, opcode=000010, imm16=0x1234, link_addr=0x24, pc=0x24.
- Halt: load ir=0xFC00_0000, then pulse PCWre/IRWre repeatedly -> halted=1 one edge later; pc, ir and fetch_cnt frozen. Assert rst=0 -> all cleared within the same cycle, halted=0.
- Wrap: pc=FFFF_FFFC, PCSrc=00, PCWre=1 -> pc=0000_0000, align_err stays 0.
